taillight_scheduler: RTL and testbench
======================================

# taillight_scheduler

Sequencing and arbitration controller for the taillight datapath. It turns raw driver requests (left, right, hazard, cancel) into one mutually exclusive registered mode select, and issues a one-cycle step enable that paces the turn-pattern FSM. It also generates the free-running PWM dimmer waveform used for running lights. It sits between the switch inputs and the taillight pattern/brake/dimmer datapath.

## Interface
Parameters:
- `TICK_DIV`, default 8, clocks per step period; must be ≥2.
- `CANCEL_STEPS`, default 24, steps before a turn mode auto-cancels; 0 disables auto-cancel.
- `PWM_PERIOD`, default 16, dimmer period in clocks; must be ≥2.
- `PWM_DUTY`, default 4, dimmer high clocks per period; must be ≤ `PWM_PERIOD`.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, reset; one clock, synchronous, active-low.
- `left_req_i`, in, 1, left stalk level.
- `right_req_i`, in, 1, right stalk level.
- `hazard_req_i`, in, 1, hazard switch level.
- `cancel_i`, in, 1, steering-return cancel, level.
- `left_o`, out, 1, left mode select to the pattern FSM.
- `right_o`, out, 1, right mode select.
- `hazard_o`, out, 1, hazard mode select.
- `step_o`, out, 1, one-cycle advance enable for the pattern FSM.
- `dimmer_o`, out, 1, PWM dimmer for running lights.
- `active_o`, out, 1, high when not IDLE.

## Operation
- Counter widths:
  - Tick counter: `$clog2(TICK_DIV)`.
  - Step counter: `$clog2(CANCEL_STEPS+1)`.
  - PWM counter: `$clog2(PWM_PERIOD)`.
  - All counters are unsigned and wrap to 0 at their terminal value.
- Edge detect: `left_req_i` and `right_req_i` are each registered once; rise = in & ~prev. The prev registers reset to 0, so a level held high through reset yields a rise on the first cycle after release.
- States: IDLE, LEFT, RIGHT, HAZARD. Outputs decode from state: `left_o` = LEFT, `right_o` = RIGHT, `hazard_o` = HAZARD, `active_o` = not IDLE. At most one select is ever high.
- Transition priority per cycle, highest first:
  1. `hazard_req_i` = 1 → HAZARD from any state.
  2. In HAZARD with `hazard_req_i` = 0 → IDLE.
  3. `cancel_i` = 1 → IDLE from LEFT/RIGHT.
  4. Left rise and right rise in the same cycle → no change.
  5. Left rise: IDLE/RIGHT → LEFT; LEFT → IDLE (toggle off).
  6. Right rise: IDLE/LEFT → RIGHT; RIGHT → IDLE.
  7. Auto-cancel: in LEFT/RIGHT, `step_o` issued while step count = `CANCEL_STEPS`-1 (and `CANCEL_STEPS` ≠ 0) → IDLE.
- Tick counter:
  - Cleared on every state change and while in IDLE.
  - Otherwise increments each cycle.
  - At `TICK_DIV`-1 it wraps and `step_o` pulses for one cycle.
- Step counter:
  - Cleared on every state change.
  - In LEFT/RIGHT, increments on each `step_o`.
  - In HAZARD it is held at 0, so hazard never auto-cancels.
- PWM:
  - Counter free-runs from reset.
  - `dimmer_o` <= (pwm_cnt < `PWM_DUTY`), so it lags the counter by one cycle.
  - `PWM_DUTY` = 0 gives constant 0; `PWM_DUTY` = `PWM_PERIOD` gives constant 1 after the first cycle.
- All outputs are registered.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, all counters 0, edge regs 0. All outputs are 0 in the following cycle, including `dimmer_o`.
- Reset asserted mid-operation aborts any mode at the next edge; no step is emitted in that cycle.
- Request latency: an input level at edge N produces the mode select change visible after edge N+1 (one cycle through the edge register, one through the state register).
- First step after entering a non-IDLE state: `step_o` high exactly `TICK_DIV` cycles after the select rises, then every `TICK_DIV` cycles.
- `step_o` never coincides with a select change and is never high in IDLE.
- Auto-cancel: the select falls one cycle after the `CANCEL_STEPS`-th step pulse. Exactly `CANCEL_STEPS` pulses occur.
- LEFT→RIGHT switch: the tick counter restarts, and the first RIGHT step comes `TICK_DIV` cycles after `right_o` rises.
- `dimmer_o`, after reset release: high for `PWM_DUTY` cycles, then low for `PWM_PERIOD`-`PWM_DUTY` cycles, repeating.

## Test plan
- Default params, pulse `left_req_i` for 1 cycle → `left_o` = 1 two cycles later. `step_o` pulses at +8, +16 … for 24 pulses total, then `left_o` drops one cycle after the 24th pulse.
- In LEFT, raise `right_req_i` → `right_o` rises and `left_o` falls in the same cycle; the next step comes 8 cycles later. A second `right_req_i` rise → IDLE, and `step_o` stays 0.
- Hold `hazard_req_i` for 300 cycles during RIGHT with left/right toggling → `hazard_o` stays 1, selects stay one-hot, 37 steps occur, no auto-cancel. Release → IDLE.
- Left and right rise in the same cycle from IDLE → state stays IDLE. `cancel_i` during LEFT → IDLE next cycle. `cancel_i` during HAZARD → ignored.
- Assert `rst_n` = 0 mid-LEFT with `left_req_i` held high → all outputs 0. After release, the held level re-enters LEFT; `dimmer_o` pattern is 4 high / 12 low from cycle 1.
- Sweep `PWM_DUTY` ∈ {0, 4, 16} and `CANCEL_STEPS` = 0 → dimmer is constant 0, 25%, and constant 1 respectively; LEFT persists indefinitely.

Source files
------------

// File: rtl/taillight_if.sv
// Request/select bundle between the switch inputs and the taillight scheduler.
// The master side drives the driver requests. The slave side returns the mode
// selects, the step pace and the dimmer waveform.
interface taillight_if;
  logic left_req_i;
  logic right_req_i;
  logic hazard_req_i;
  logic cancel_i;
  logic left_o;
  logic right_o;
  logic hazard_o;
  logic step_o;
  logic dimmer_o;
  logic active_o;

  modport master (
    output left_req_i, right_req_i, hazard_req_i, cancel_i,
    input  left_o, right_o, hazard_o, step_o, dimmer_o, active_o
  );

  modport slave (
    input  left_req_i, right_req_i, hazard_req_i, cancel_i,
    output left_o, right_o, hazard_o, step_o, dimmer_o, active_o
  );
endinterface

// File: rtl/taillight_scheduler.sv
// Taillight scheduler.
// Arbitrates the left, right, hazard and cancel requests into one registered,
// mutually exclusive mode select. It paces the pattern FSM with a one-cycle
// step enable and generates the free-running PWM dimmer for the running lights.
module taillight_scheduler #(
  parameter int TICK_DIV     = 8,
  parameter int CANCEL_STEPS = 24,
  parameter int PWM_PERIOD   = 16,
  parameter int PWM_DUTY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  taillight_if.slave  bus
);

  // Counter widths. The step counter keeps one bit when auto-cancel is disabled.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (CANCEL_STEPS > 0) ? $clog2(CANCEL_STEPS + 1) : 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'((CANCEL_STEPS > 0) ? CANCEL_STEPS - 1 : 0);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      turn_req;       // bit 0 = left, bit 1 = right
  logic [1:0]      turn_prev_reg;
  logic [1:0]      turn_rise_reg;
  logic [TW-1:0]   tick_reg;
  logic [SW-1:0]   step_cnt_reg;
  logic [PW-1:0]   pwm_cnt_reg;
  logic            step_reg, dimmer_reg;
  logic            left_reg, right_reg, hazard_reg, active_reg;
  logic            in_turn, auto_cancel, state_change;

  assign turn_req = {bus.right_req_i, bus.left_req_i};

  // The rise is registered, so a stalk request reaches the state register one
  // cycle later. prev clears on reset, so a level held through reset counts as a rise.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          turn_prev_reg[gi] <= 1'b0;
          turn_rise_reg[gi] <= 1'b0;
        end else begin
          turn_prev_reg[gi] <= turn_req[gi];
          turn_rise_reg[gi] <= turn_req[gi] & ~turn_prev_reg[gi];
        end
      end
    end
  endgenerate

  // Next-state decode, highest-priority request first.
  always_comb begin
    in_turn     = (state_reg == LEFT) || (state_reg == RIGHT);
    auto_cancel = (CANCEL_STEPS != 0) && in_turn && step_reg &&
                  (step_cnt_reg == STEP_LAST);
    state_next  = state_reg;
    if (bus.hazard_req_i) begin
      state_next = HAZARD;
    end else if (state_reg == HAZARD) begin
      state_next = IDLE;
    end else if (bus.cancel_i && in_turn) begin
      state_next = IDLE;
    end else if (turn_rise_reg[0] && turn_rise_reg[1]) begin
      state_next = state_reg;
    end else if (turn_rise_reg[0]) begin
      state_next = (state_reg == LEFT) ? IDLE : LEFT;
    end else if (turn_rise_reg[1]) begin
      state_next = (state_reg == RIGHT) ? IDLE : RIGHT;
    end else if (auto_cancel) begin
      state_next = IDLE;
    end
    state_change = (state_next != state_reg);
  end

  // Mode FSM with registered selects, the step pacing tick and the auto-cancel step count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      left_reg     <= 1'b0;
      right_reg    <= 1'b0;
      hazard_reg   <= 1'b0;
      active_reg   <= 1'b0;
      tick_reg     <= '0;
      step_reg     <= 1'b0;
      step_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      left_reg   <= (state_next == LEFT);
      right_reg  <= (state_next == RIGHT);
      hazard_reg <= (state_next == HAZARD);
      active_reg <= (state_next != IDLE);

      // The tick restarts on every mode change, so no step lands on a select edge.
      if (state_change || state_reg == IDLE) begin
        tick_reg <= '0;
        step_reg <= 1'b0;
      end else if (tick_reg == TICK_LAST) begin
        tick_reg <= '0;
        step_reg <= 1'b1;
      end else begin
        tick_reg <= tick_reg + 1'b1;
        step_reg <= 1'b0;
      end

      // Hazard pins the count at zero so it never auto-cancels.
      if (state_change || state_reg == HAZARD) begin
        step_cnt_reg <= '0;
      end else if (in_turn && step_reg) begin
        step_cnt_reg <= step_cnt_reg + 1'b1;
      end
    end
  end

  // Free-running dimmer PWM. The output lags the counter by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
      dimmer_reg  <= 1'b0;
    end else begin
      pwm_cnt_reg <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
      dimmer_reg  <= (32'(pwm_cnt_reg) < 32'(PWM_DUTY));
    end
  end

  assign bus.left_o   = left_reg;
  assign bus.right_o  = right_reg;
  assign bus.hazard_o = hazard_reg;
  assign bus.step_o   = step_reg;
  assign bus.dimmer_o = dimmer_reg;
  assign bus.active_o = active_reg;

endmodule

// File: tb/tb_taillight_scheduler.sv
// Directed testbench for taillight_scheduler: one default-parameter DUT plus
// three auto-cancel-disabled DUTs sweeping the dimmer duty cycle.
module tb_taillight_scheduler;

  logic clk;
  logic rst_n;

  taillight_if m_if ();
  taillight_if d0_if ();
  taillight_if d4_if ();
  taillight_if d16_if ();

  taillight_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  taillight_scheduler #(.CANCEL_STEPS(0), .PWM_DUTY(0)) dut_d0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d0_if.slave)
  );

  taillight_scheduler #(.CANCEL_STEPS(0), .PWM_DUTY(4)) dut_d4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d4_if.slave)
  );

  taillight_scheduler #(.CANCEL_STEPS(0), .PWM_DUTY(16)) dut_d16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d16_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sel();
    return {m_if.left_o, m_if.right_o, m_if.hazard_o};
  endfunction

  // Watchdog: every phase is bounded, but the run must end even if the clock stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nsteps, first, last, drop, nh, bad;
    int cnt0, cnt4, cnt16, sweep_low, sweep_steps;

    rst_n = 1'b0;
    m_if.left_req_i = 1'b0;   m_if.right_req_i = 1'b0;
    m_if.hazard_req_i = 1'b0; m_if.cancel_i = 1'b0;
    d0_if.left_req_i = 1'b1;  d0_if.right_req_i = 1'b0;
    d0_if.hazard_req_i = 1'b0; d0_if.cancel_i = 1'b0;
    d4_if.left_req_i = 1'b1;  d4_if.right_req_i = 1'b0;
    d4_if.hazard_req_i = 1'b0; d4_if.cancel_i = 1'b0;
    d16_if.left_req_i = 1'b1; d16_if.right_req_i = 1'b0;
    d16_if.hazard_req_i = 1'b0; d16_if.cancel_i = 1'b0;

    cyc(); cyc();
    check("reset_outs", {sel(), m_if.step_o, m_if.dimmer_o, m_if.active_o}, 0);
    rst_n = 1'b1;

    // Left pulse, then auto-cancel after 24 steps
    $display("txn: left pulse from IDLE, run to auto-cancel");
    m_if.left_req_i = 1'b1;
    cyc();
    check("left_lat1", m_if.left_o, 0);
    m_if.left_req_i = 1'b0;
    cyc();
    check("left_lat2", {sel(), m_if.active_o}, 4'b1001);
    nsteps = 0; first = -1; last = -1; drop = -1;
    for (int k = 1; k <= 300 && drop < 0; k++) begin
      cyc();
      if (m_if.step_o) begin
        nsteps++;
        if (first < 0) first = k;
        last = k;
      end
      if (!m_if.left_o) drop = k;
    end
    check("auto_steps", nsteps, 24);
    check("auto_first_step", first, 8);
    check("auto_last_step", last, 192);
    check("auto_drop", drop, 193);

    // LEFT -> RIGHT switch, then toggle RIGHT off
    $display("txn: LEFT then right rise, then second right rise");
    m_if.left_req_i = 1'b1; cyc(); m_if.left_req_i = 1'b0; cyc();
    check("t2_left", sel(), 3'b100);
    cyc(); cyc(); cyc();
    m_if.right_req_i = 1'b1;
    cyc();
    check("t2_hold", sel(), 3'b100);
    cyc();
    check("t2_switch", sel(), 3'b010);
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      cyc();
      if (m_if.step_o) first = k;
    end
    check("t2_first_step", first, 8);
    m_if.right_req_i = 1'b0; cyc();
    m_if.right_req_i = 1'b1; cyc();
    check("t2_second_rise_hold", sel(), 3'b010);
    cyc();
    check("t2_toggle_off", {sel(), m_if.active_o}, 0);
    nsteps = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (m_if.step_o) nsteps++;
    end
    check("t2_idle_steps", nsteps, 0);
    m_if.right_req_i = 1'b0;
    cyc();

    // Hazard held 300 cycles during RIGHT with stalk and cancel noise
    $display("txn: hazard held 300 cycles over RIGHT");
    m_if.right_req_i = 1'b1; cyc(); m_if.right_req_i = 1'b0; cyc();
    check("t3_right", sel(), 3'b010);
    m_if.hazard_req_i = 1'b1;
    nh = 0; nsteps = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      m_if.left_req_i  = (i % 3 == 0);
      m_if.right_req_i = (i % 5 == 1);
      m_if.cancel_i    = (i % 7 == 3);
      cyc();
      if (i == 0) check("t3_hazard_entry", sel(), 3'b001);
      if (m_if.hazard_o) nh++;
      if (m_if.hazard_o && m_if.step_o) nsteps++;
      if (int'(m_if.left_o) + int'(m_if.right_o) + int'(m_if.hazard_o) > 1) bad++;
    end
    m_if.hazard_req_i = 1'b0; m_if.left_req_i = 1'b0;
    m_if.right_req_i = 1'b0;  m_if.cancel_i = 1'b0;
    cyc();
    check("t3_release", {sel(), m_if.active_o}, 0);
    check("t3_hazard_cycles", nh, 300);
    check("t3_hazard_steps", nsteps, 37);
    check("t3_onehot_violations", bad, 0);

    // Simultaneous rises, cancel in LEFT, cancel in HAZARD
    $display("txn: simultaneous rises and cancel");
    m_if.left_req_i = 1'b1; m_if.right_req_i = 1'b1;
    cyc(); cyc();
    check("t4_both_rise", {sel(), m_if.active_o}, 0);
    m_if.left_req_i = 1'b0; m_if.right_req_i = 1'b0;
    cyc();
    m_if.left_req_i = 1'b1; cyc(); m_if.left_req_i = 1'b0; cyc();
    check("t4_left", sel(), 3'b100);
    cyc();
    m_if.cancel_i = 1'b1;
    cyc();
    check("t4_cancel_left", {sel(), m_if.active_o}, 0);
    m_if.cancel_i = 1'b0;
    m_if.hazard_req_i = 1'b1;
    cyc();
    check("t4_hazard", sel(), 3'b001);
    m_if.cancel_i = 1'b1;
    cyc(); cyc();
    check("t4_cancel_hazard", sel(), 3'b001);
    m_if.cancel_i = 1'b0; m_if.hazard_req_i = 1'b0;
    cyc();
    check("t4_hazard_off", {sel(), m_if.active_o}, 0);

    // Reset mid-LEFT with the stalk held, then dimmer and duty sweep
    $display("txn: reset mid-LEFT with left held, duty sweep");
    m_if.left_req_i = 1'b1;
    cyc(); cyc();
    check("t5_left", sel(), 3'b100);
    for (int k = 0; k < 5; k++) cyc();
    rst_n = 1'b0;
    cyc();
    check("t5_reset_main", {sel(), m_if.step_o, m_if.dimmer_o, m_if.active_o}, 0);
    check("t5_reset_sweep", {d0_if.left_o, d4_if.left_o, d16_if.left_o,
                             d16_if.dimmer_o, d4_if.dimmer_o}, 0);
    rst_n = 1'b1;
    cnt0 = 0; cnt4 = 0; cnt16 = 0; sweep_low = 0; sweep_steps = 0;
    for (int c = 1; c <= 320; c++) begin
      cyc();
      if (c == 1) check("t5_release_c1", m_if.left_o, 0);
      if (c == 2) check("t5_reenter", sel(), 3'b100);
      if (c <= 32) check("t5_dimmer", m_if.dimmer_o, 32'(((c - 1) % 16) < 4));
      cnt0  += int'(d0_if.dimmer_o);
      cnt4  += int'(d4_if.dimmer_o);
      cnt16 += int'(d16_if.dimmer_o);
      if (c >= 2 && !(d0_if.left_o && d4_if.left_o && d16_if.left_o)) sweep_low++;
      if (d4_if.step_o) sweep_steps++;
    end
    check("sweep_duty0_high", cnt0, 0);
    check("sweep_duty4_high", cnt4, 80);
    check("sweep_duty16_high", cnt16, 320);
    check("sweep_left_dropped", sweep_low, 0);
    check("sweep_steps", sweep_steps, 39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
